// File: rtl/lcd_driver.sv
// lcd_driver: 4-bit HD44780-style LCD driver that initialises the panel and refreshes two 16-char rows.
// Define LCD_CHANGE_DETECT_EN to idle between frames until {line1,line2} changes.
module lcd_driver #(
  parameter int T_PWR  = 750000,
  parameter int T_INIT = 205000,
  parameter int T_E    = 12,
  parameter int T_NIB  = 50,
  parameter int T_CMD  = 2000,
  parameter int T_CLR  = 82000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [3:0]   lcd_data,
  output logic         ready,
  output logic         frame_done
);
  localparam int M1 = (T_PWR > T_INIT) ? T_PWR : T_INIT;
  localparam int M2 = (M1 > T_CLR) ? M1 : T_CLR;
  localparam int M3 = (M2 > T_CMD) ? M2 : T_CMD;
  localparam int M4 = (M3 > T_NIB) ? M3 : T_NIB;
  localparam int TMAX = (M4 > T_E) ? M4 : T_E;
  localparam int CW = ($clog2(TMAX + 1) > 20) ? $clog2(TMAX + 1) : 20;

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_CFG, S_FRAME
`ifdef LCD_CHANGE_DETECT_EN
    , S_IDLE
`endif
  } st_t;
  typedef enum logic [2:0] {P_SET, P_EH, P_GAP, P_EL, P_WAIT} ph_t;

`ifdef LCD_CHANGE_DETECT_EN
  localparam st_t S_AFTER = S_IDLE;
`else
  localparam st_t S_AFTER = S_FRAME;
`endif

  // A phase of N cycles loads N-1 and advances when the counter reaches 0.
  function automatic logic [CW-1:0] ld(input int n);
    return (n > 0) ? CW'(n - 1) : '0;
  endfunction

  st_t           st_q, st_d;
  ph_t           ph_q, ph_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, wt;
  logic [255:0]  snap_q;
  logic          ready_q, ready_d;
  logic [7:0]    byt, cfg_b, frm_b;
  logic          rs, cmd, last, done, xfer, hi, grab, rot;

  assign done  = cnt_q == '0;
  assign xfer  = st_q == S_INIT || st_q == S_CFG || st_q == S_FRAME;
  assign cmd   = idx_q == 6'd0 || idx_q == 6'd17;
  assign cfg_b = (idx_q == 6'd0) ? 8'h28 : (idx_q == 6'd1) ? 8'h06 : (idx_q == 6'd2) ? 8'h0C : 8'h01;
  // The snapshot rotates one char per data byte, so the current char is always the top byte.
  assign frm_b = (idx_q == 6'd0) ? 8'h80 : (idx_q == 6'd17) ? 8'hC0 : snap_q[255:248];
  assign byt   = (st_q == S_INIT) ? {(idx_q == 6'd3) ? 4'h2 : 4'h3, 4'h0} :
                 (st_q == S_CFG) ? cfg_b : (st_q == S_FRAME) ? frm_b : 8'h00;
  assign rs    = st_q == S_FRAME && !cmd;
  assign last  = (st_q == S_FRAME) ? idx_q == 6'd33 : idx_q == 6'd3;
  assign wt    = (st_q == S_INIT) ? ld(T_INIT) : (st_q == S_CFG && idx_q == 6'd3) ? ld(T_CLR) : ld(T_CMD);
  assign grab  = st_q == S_FRAME && idx_q == 6'd0 && ph_q == P_SET;
  assign rot   = st_q == S_FRAME && ph_q == P_WAIT && done && rs;
  // Upper nibble is held into the gap and swapped one cycle before the second E pulse.
  assign hi    = st_q == S_INIT || ph_q == P_SET || ph_q == P_EH || (ph_q == P_GAP && !done);

  assign lcd_e      = xfer && (ph_q == P_EH || ph_q == P_EL);
  assign lcd_rs     = xfer && rs;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = xfer ? (hi ? byt[7:4] : byt[3:0]) : 4'h0;
  assign ready      = ready_q;
  assign frame_done = st_q == S_FRAME && ph_q == P_WAIT && done && last;

  always_comb begin
    st_d    = st_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    cnt_d   = done ? cnt_q : cnt_q - 1'b1;
    ready_d = ready_q;
    if (st_q == S_PWR) begin
      if (ph_q == P_SET) begin
        ph_d  = P_WAIT;
        cnt_d = ld(T_PWR);
      end else if (done) begin
        st_d  = S_INIT;
        ph_d  = P_SET;
        idx_d = 6'd0;
      end
`ifdef LCD_CHANGE_DETECT_EN
    end else if (st_q == S_IDLE) begin
      if ({line1, line2} != snap_q) st_d = S_FRAME;
`endif
    end else if (done) begin
      case (ph_q)
        P_SET: begin
          ph_d  = P_EH;
          cnt_d = ld(T_E);
        end
        P_EH: begin
          ph_d  = (st_q == S_INIT) ? P_WAIT : P_GAP;
          cnt_d = (st_q == S_INIT) ? wt : ld(T_NIB);
        end
        P_GAP: begin
          ph_d  = P_EL;
          cnt_d = ld(T_E);
        end
        P_EL: begin
          ph_d  = P_WAIT;
          cnt_d = wt;
        end
        default: begin
          ph_d  = P_SET;
          idx_d = last ? 6'd0 : idx_q + 6'd1;
          if (last) st_d = (st_q == S_INIT) ? S_CFG : (st_q == S_CFG) ? S_FRAME : S_AFTER;
          if (last && st_q == S_CFG) ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= S_PWR;
      ph_q    <= P_SET;
      idx_q   <= 6'd0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      if (grab) snap_q <= {line1, line2};
      else if (rot) snap_q <= {snap_q[247:0], snap_q[255:248]};
    end
  end
endmodule
